// File: rtl/spi_master.sv
// SPI master (mode 0) carrying one host command per frame: an 11-bit command frame on MOSI,
// plus a dummy period and an 8-bit MISO read-back for read-data commands.
module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, SHIFT_OUT, TURN, SHIFT_IN, GAP} state_t;

    localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  frame_q, frame_d;
    logic [7:0]  rx_q, rx_d;
    logic        is_rd_q, is_rd_d;
    logic        sclk_q, sclk_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic accept_s, wrap_s, rise_s, fall_s;

    assign accept_s = cmd_valid && cmd_ready_q && (state_q == IDLE);
    assign wrap_s   = (cnt_q == DIV_LAST);
    assign rise_s   = wrap_s && !sclk_q;
    assign fall_s   = wrap_s && sclk_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; every phase ends on an SCLK falling edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept_s) state_d = SHIFT_OUT; else state_d = IDLE;
            SHIFT_OUT: if (fall_s && bit_q == 4'd10) state_d = is_rd_q ? TURN : GAP;
                       else state_d = SHIFT_OUT;
            TURN:      if (fall_s) state_d = SHIFT_IN; else state_d = TURN;
            SHIFT_IN:  if (fall_s && bit_q == 4'd7) state_d = GAP; else state_d = SHIFT_IN;
            GAP:       if (cnt_q == GAP_LAST) state_d = IDLE; else state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the frame's first bit is driven straight from acceptance
    always_comb begin
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rx_d        = rx_q;
        is_rd_d     = is_rd_q;
        sclk_d      = sclk_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                cnt_d  = 9'd0;
                sclk_d = 1'b0;
                if (accept_s) begin
                    ss_n_d  = 1'b0;
                    mosi_d  = cmd[1];
                    frame_d = {cmd, cmd_data};
                    is_rd_d = (cmd == 2'b11);
                    bit_d   = 4'd0;
                    rx_d    = 8'h00;
                end else begin
                    ss_n_d = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            SHIFT_OUT: begin
                cnt_d = wrap_s ? 9'd0 : cnt_q + 9'd1;
                if (rise_s) begin
                    sclk_d = 1'b1;
                end else if (fall_s) begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd10) begin
                        bit_d  = 4'd0;
                        mosi_d = 1'b0;
                        ss_n_d = !is_rd_q;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        mosi_d  = frame_q[9];
                        frame_d = {frame_q[8:0], 1'b0};
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            TURN: begin
                cnt_d  = wrap_s ? 9'd0 : cnt_q + 9'd1;
                mosi_d = 1'b0;
                if (rise_s)      sclk_d = 1'b1;
                else if (fall_s) begin sclk_d = 1'b0; bit_d = 4'd0; end
                else             sclk_d = sclk_q;
            end
            SHIFT_IN: begin
                cnt_d  = wrap_s ? 9'd0 : cnt_q + 9'd1;
                mosi_d = 1'b0;
                if (rise_s) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], MISO};
                end else if (fall_s) begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd7) begin
                        bit_d       = 4'd0;
                        ss_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_q;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            GAP: begin
                cnt_d  = (cnt_q == GAP_LAST) ? 9'd0 : cnt_q + 9'd1;
                sclk_d = 1'b0;
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
            end
            default: begin
                cnt_d  = 9'd0;
                sclk_d = 1'b0;
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 9'd0;
            bit_q       <= 4'd0;
            frame_q     <= 10'd0;
            rx_q        <= 8'h00;
            is_rd_q     <= 1'b0;
            sclk_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rx_q        <= rx_d;
            is_rd_q     <= is_rd_d;
            sclk_q      <= sclk_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 1/2/3) behind an output mux, a mode-0 slave
// model, a frame monitor and an expected-frame scoreboard.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       miso = 1'b0;
    logic [1:0] sel = 2'd1;
    logic [7:0] slave_byte = 8'h00;

    logic [2:0] cv, ready_v, rv_v, busy_v, ss_v, sclk_v, mosi_v;
    logic [7:0] rdata_v [3];

    assign cv[0] = cmd_valid && (sel == 2'd0);
    assign cv[1] = cmd_valid && (sel == 2'd1);
    assign cv[2] = cmd_valid && (sel == 2'd2);

    spi_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(ready_v[0]),
        .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rv_v[0]), .rsp_data(rdata_v[0]), .busy(busy_v[0]),
        .SS_n(ss_v[0]), .SCLK(sclk_v[0]), .MOSI(mosi_v[0]), .MISO(miso));
    spi_master #(.CLK_DIV(2)) u_d2 (.clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(ready_v[1]),
        .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rv_v[1]), .rsp_data(rdata_v[1]), .busy(busy_v[1]),
        .SS_n(ss_v[1]), .SCLK(sclk_v[1]), .MOSI(mosi_v[1]), .MISO(miso));
    spi_master #(.CLK_DIV(3)) u_d3 (.clk(clk), .rst(rst), .cmd_valid(cv[2]), .cmd_ready(ready_v[2]),
        .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rv_v[2]), .rsp_data(rdata_v[2]), .busy(busy_v[2]),
        .SS_n(ss_v[2]), .SCLK(sclk_v[2]), .MOSI(mosi_v[2]), .MISO(miso));

    logic       s_ready, s_rv, s_busy, s_ss_n, s_sclk, s_mosi;
    logic [7:0] s_rdata;
    assign s_ready = ready_v[sel];
    assign s_rv    = rv_v[sel];
    assign s_busy  = busy_v[sel];
    assign s_ss_n  = ss_v[sel];
    assign s_sclk  = sclk_v[sel];
    assign s_mosi  = mosi_v[sel];
    assign s_rdata = rdata_v[sel];

    int checks = 0;
    int errors = 0;

    // Mode-0 slave: presents the read byte MSB first after the 12th SCLK fall
    int         fall_n = 0;
    logic [7:0] sh = 8'h00;
    always @(negedge s_sclk or posedge s_ss_n) begin
        if (s_ss_n) begin
            fall_n <= 0;
            miso   <= 1'b0;
        end else begin
            fall_n <= fall_n + 1;
            if (fall_n == 11) begin
                miso <= slave_byte[7];
                sh   <= slave_byte << 1;
            end else if (fall_n >= 12 && fall_n < 19) begin
                miso <= sh[7];
                sh   <= sh << 1;
            end
        end
    end

    // Frame monitor: MOSI at SCLK rises, SS_n low/high lengths, rsp_valid activity
    logic        prev_ss = 1'b1, prev_sclk = 1'b0;
    int          low_cnt = 0, hi_cnt = 0, last_hi = 0, rv_cnt = 0, rv_total = 0, stuck = 0, ss_sclk_err = 0, nb = 0;
    logic [19:0] bits = 20'd0;
    int          obs_len[$], obs_nb[$], obs_rv[$], obs_stuck[$];
    logic [19:0] obs_bits[$];
    logic [7:0]  obs_rsp[$];
    int          exp_len[$], exp_nb[$], exp_rv[$];
    logic [19:0] exp_bits[$];
    logic [7:0]  exp_rsp[$];

    always @(negedge clk) begin
        prev_ss   <= s_ss_n;
        prev_sclk <= s_sclk;
        if (s_rv === 1'b1) rv_total <= rv_total + 1;
        if (s_ss_n === 1'b1 && s_sclk === 1'b1) ss_sclk_err <= ss_sclk_err + 1;
        if (s_ss_n === 1'b0) begin
            if (prev_ss === 1'b1) begin
                low_cnt <= 1; bits <= 20'd0; nb <= 0; rv_cnt <= 0; stuck <= 0; last_hi <= hi_cnt;
            end else begin
                low_cnt <= low_cnt + 1;
                if (s_sclk && !prev_sclk) begin
                    bits <= {bits[18:0], s_mosi};
                    nb   <= nb + 1;
                end
                if (s_sclk == prev_sclk) stuck <= stuck + 1;
                if (s_rv === 1'b1) rv_cnt <= rv_cnt + 1;
            end
        end else if (s_ss_n === 1'b1) begin
            if (prev_ss === 1'b0) begin
                obs_len.push_back(low_cnt);
                obs_bits.push_back(bits);
                obs_nb.push_back(nb);
                obs_rv.push_back(rv_cnt + ((s_rv === 1'b1) ? 1 : 0));
                obs_rsp.push_back(s_rdata);
                obs_stuck.push_back(stuck);
                hi_cnt <= 1;
            end else begin
                hi_cnt <= hi_cnt + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] c, input logic [7:0] d, input int div, input logic [7:0] rsp);
        if (c == 2'b11) begin
            exp_bits.push_back({c[1], c, d, 9'd0}); exp_nb.push_back(20);
            exp_len.push_back(40 * div); exp_rv.push_back(1); exp_rsp.push_back(rsp);
        end else begin
            exp_bits.push_back({9'd0, c[1], c, d}); exp_nb.push_back(11);
            exp_len.push_back(22 * div); exp_rv.push_back(0); exp_rsp.push_back(8'h00);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (s_ready === 1'b1) ok = 1'b1;
            else tick(1);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL issue_timeout: cmd_ready=%b required 1", s_ready); end
        cmd = c; cmd_data = d; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0; cmd = ~c; cmd_data = ~d;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (obs_len.size() > 0 && exp_len.size() > 0) ok = 1'b1;
            else tick(1);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_timeout: frames=%0d required 1", obs_len.size()); end
    endtask

    // Pops one observed and one expected frame and compares them field by field
    task automatic test_frame(input string name, input bit chk_stuck);
        bit ok;
        int len, xlen, n, xn, rv, xrv, st;
        logic [19:0] b, xb;
        logic [7:0] r, xr;
        wait_frame(ok);
        if (ok) begin
            len = obs_len.pop_front(); b = obs_bits.pop_front(); n = obs_nb.pop_front();
            rv = obs_rv.pop_front(); r = obs_rsp.pop_front(); st = obs_stuck.pop_front();
            xlen = exp_len.pop_front(); xb = exp_bits.pop_front(); xn = exp_nb.pop_front();
            xrv = exp_rv.pop_front(); xr = exp_rsp.pop_front();
            checks += 4;
            if (len !== xlen) begin errors++; $display("FAIL %s_ss_low: got %0d required %0d", name, len, xlen); end
            if (n !== xn || b !== xb) begin errors++; $display("FAIL %s_bits: got %0d/%b required %0d/%b", name, n, b, xn, xb); end
            if (rv !== xrv) begin errors++; $display("FAIL %s_rsp_valid: got %0d required %0d", name, rv, xrv); end
            if (xrv == 1 && r !== xr) begin errors++; $display("FAIL %s_rsp_data: got %h required %h", name, r, xr); end
            if (chk_stuck) begin
                checks++;
                if (st !== 0) begin errors++; $display("FAIL %s_sclk_toggle: stalls %0d required 0", name, st); end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 2'd1;
        tick(3);
        checks++;
        if ({s_ss_n, s_sclk, s_mosi, s_rv, s_busy, s_ready} !== 6'b100000 || s_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_state: got %b/%h required 100000/00", {s_ss_n, s_sclk, s_mosi, s_rv, s_busy, s_ready}, s_rdata);
        end
        rst = 1'b0; tick(1);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", s_ready); end
        issue(2'b01, 8'h5B);
        tick(12);
        checks++;
        if (s_busy !== 1'b1 || s_ss_n !== 1'b0) begin errors++; $display("FAIL midframe_active: busy=%b ss_n=%b required 1/0", s_busy, s_ss_n); end
        rst = 1'b1; tick(1);
        checks++;
        if ({s_ss_n, s_sclk, s_mosi, s_rv, s_busy} !== 5'b10000) begin
            errors++; $display("FAIL reset_abort: got %b required 10000", {s_ss_n, s_sclk, s_mosi, s_rv, s_busy});
        end
        tick(1);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b required 0", s_ready); end
        tick(1);
        rst = 1'b0; tick(1);
        checks++;
        if (s_ready !== 1'b1 || rv_total !== 0) begin errors++; $display("FAIL reset_release: ready=%b rv=%0d required 1/0", s_ready, rv_total); end
        obs_len.delete(); obs_bits.delete(); obs_nb.delete(); obs_rv.delete(); obs_rsp.delete(); obs_stuck.delete();
    endtask

    task automatic test_write_addr();
        sel = 2'd1;
        push_exp(2'b00, 8'h3C, 2, 8'h00);
        issue(2'b00, 8'h3C);
        test_frame("write_addr", 1'b0);
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        sel = 2'd1;
        tick(10);
        push_exp(2'b01, 8'hA7, 2, 8'h00);
        push_exp(2'b10, 8'h10, 2, 8'h00);
        cmd = 2'b01; cmd_data = 8'hA7; cmd_valid = 1'b1;
        tick(1);
        cmd = 2'b10; cmd_data = 8'h10;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (obs_len.size() == 1 && s_ss_n === 1'b0) ok = 1'b1;
            else tick(1);
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_second_start: frames=%0d required 1", obs_len.size()); end
        test_frame("b2b_first", 1'b0);
        test_frame("b2b_second", 1'b0);
        checks++;
        if (last_hi !== 5) begin errors++; $display("FAIL b2b_gap: ss_n high %0d cycles required 5", last_hi); end
    endtask

    task automatic test_read_div3();
        sel = 2'd2; slave_byte = 8'hA5;
        tick(5);
        push_exp(2'b11, 8'h6E, 3, 8'hA5);
        issue(2'b11, 8'h6E);
        test_frame("read_div3", 1'b0);
    endtask

    task automatic test_busy_protect();
        sel = 2'd1;
        tick(5);
        push_exp(2'b10, 8'hC3, 2, 8'h00);
        issue(2'b10, 8'hC3);
        tick(8);
        cmd = 2'b00; cmd_data = 8'hFF; cmd_valid = 1'b1;
        tick(1);
        checks++;
        if (s_ready !== 1'b0 || s_busy !== 1'b1) begin errors++; $display("FAIL busy_ready: ready=%b busy=%b required 0/1", s_ready, s_busy); end
        tick(10);
        cmd_valid = 1'b0;
        test_frame("busy_frame", 1'b0);
        tick(20);
        checks++;
        if (s_ss_n !== 1'b1 || obs_len.size() != 0) begin errors++; $display("FAIL busy_not_taken: ss_n=%b frames=%0d required 1/0", s_ss_n, obs_len.size()); end
    endtask

    task automatic test_read_div1();
        sel = 2'd0; slave_byte = 8'h5A;
        tick(5);
        push_exp(2'b11, 8'h81, 1, 8'h5A);
        issue(2'b11, 8'h81);
        test_frame("read_div1", 1'b1);
        tick(5);
        checks++;
        if (s_rdata !== 8'h5A) begin errors++; $display("FAIL rsp_hold: got %h required 5a", s_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_read_div3();
        test_busy_protect();
        test_read_div1();
        checks++;
        if (rv_total !== 2 || ss_sclk_err !== 0) begin
            errors++; $display("FAIL global: rsp_valid cycles %0d sclk-while-deselected %0d required 2/0", rv_total, ss_sclk_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
